// File: rtl/mem_stage_nb.sv
// Memory stage between EX and WB for a split-transaction data bus: waits for load data,
// extracts and extends it, holds it under WB back-pressure and drains responses of flushed loads.
module mem_stage_nb #(
  parameter int unsigned DW     = 32,
  parameter int unsigned PASS_W = 64,
  parameter int unsigned OFS_W  = $clog2(DW / 8)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              w_allowin,
  output logic              m_allowin,
  input  logic              em_valid,
  input  logic [PASS_W-1:0] em_pass,
  input  logic              em_load,
  input  logic [2:0]        em_ldop,
  input  logic [OFS_W-1:0]  em_ofs,
  input  logic [DW-1:0]     em_result,
  input  logic              em_ex,
  input  logic              flush,
  input  logic              data_ok,
  input  logic [DW-1:0]     rdata,
  output logic              mw_valid,
  output logic [PASS_W-1:0] mw_pass,
  output logic [DW-1:0]     mw_result,
  output logic              mw_ex,
  output logic              fwd_busy,
  output logic [DW-1:0]     fwd_data
);

  typedef enum logic [1:0] {StIdle, StWait, StHeld, StDrain} state_e;

  state_e            state_q;
  logic              m_valid_q;
  logic              load_q;
  logic              ex_q;
  logic [PASS_W-1:0] pass_q;
  logic [2:0]        ldop_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [DW-1:0]     result_q;
  logic [DW-1:0]     held_q;
  logic [1:0]        cancel_cnt_q;

  logic              in_wait;
  logic              ready_go;
  logic              accept;
  logic              advance;
  logic              wait_cancel;
  logic              ex_load;
  logic              drain_dec;
  logic [2:0]        cnt_sum;
  logic [1:0]        cnt_flush;

  logic [DW-1:0]     load_src;
  logic [OFS_W-1:0]  lane;
  logic [DW-1:0]     shifted;
  logic [DW-1:0]     mask;
  logic              sign_bit;
  logic [DW-1:0]     load_val;

  assign in_wait  = (state_q == StWait);
  assign ready_go = !load_q || data_ok || (state_q == StHeld);

  assign mw_valid  = m_valid_q && ready_go && !flush;
  assign m_allowin = (!m_valid_q || (ready_go && w_allowin)) && (cancel_cnt_q == 2'd0);
  assign accept    = em_valid && m_allowin && !flush;
  assign advance   = m_valid_q && ready_go && w_allowin;

  // A response coinciding with the flush belongs to the flushed load and is consumed here.
  assign wait_cancel = in_wait && !data_ok;
  assign ex_load     = em_valid && em_load && !em_ex;
  assign drain_dec   = (state_q == StDrain) && data_ok && (cancel_cnt_q != 2'd0);
  assign cnt_sum     = 3'(cancel_cnt_q) - 3'(drain_dec) + 3'(wait_cancel) + 3'(ex_load);
  assign cnt_flush   = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];

  // Extraction: align the offset to the access size, shift the lane down, then mask/extend.
  always_comb begin
    load_src = (state_q == StHeld) ? held_q : rdata;
    case (ldop_q[1:0])
      2'd0: begin
        lane = ofs_q;
        mask = DW'(8'hFF);
      end
      2'd1: begin
        lane = ofs_q & ~OFS_W'(1);
        mask = DW'(16'hFFFF);
      end
      2'd2: begin
        lane = ofs_q & ~OFS_W'(3);
        mask = DW'(32'hFFFF_FFFF);
      end
      default: begin
        lane = '0;
        mask = '1;
      end
    endcase
    shifted = load_src >> {lane, 3'b000};
    case (ldop_q[1:0])
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DW-1];
    endcase
    load_val = (!ldop_q[2] && sign_bit) ? (shifted | ~mask) : (shifted & mask);
  end

  assign mw_pass   = pass_q;
  assign mw_result = load_q ? load_val : result_q;
  assign mw_ex     = m_valid_q && ex_q;
  assign fwd_busy  = m_valid_q && in_wait && !data_ok;
  assign fwd_data  = mw_result;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      m_valid_q    <= 1'b0;
      load_q       <= 1'b0;
      ex_q         <= 1'b0;
      pass_q       <= '0;
      ldop_q       <= '0;
      ofs_q        <= '0;
      result_q     <= '0;
      held_q       <= '0;
      cancel_cnt_q <= 2'd0;
    end else if (flush) begin
      m_valid_q    <= 1'b0;
      cancel_cnt_q <= cnt_flush;
      state_q      <= (cnt_flush != 2'd0) ? StDrain : StIdle;
    end else if (state_q == StDrain) begin
      if (data_ok) begin
        cancel_cnt_q <= cancel_cnt_q - 2'(cancel_cnt_q != 2'd0);
        if (cancel_cnt_q <= 2'd1) state_q <= StIdle;
      end
    end else begin
      if (in_wait && data_ok && !w_allowin) begin
        held_q  <= rdata;
        state_q <= StHeld;
      end
      if (accept) begin
        m_valid_q <= 1'b1;
        load_q    <= em_load && !em_ex;
        ex_q      <= em_ex;
        pass_q    <= em_pass;
        ldop_q    <= em_ldop;
        ofs_q     <= em_ofs;
        result_q  <= em_result;
        state_q   <= (em_load && !em_ex) ? StWait : StIdle;
      end else if (advance) begin
        m_valid_q <= 1'b0;
        state_q   <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_nb.sv
// Bench for mem_stage_nb: a 32-bit and a 64-bit instance share stimulus; results are
// checked through per-instance scoreboards plus direct checks of flow-control outputs.
module tb_mem_stage_nb;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        w_allowin, em_valid, em_load, em_ex, flush, data_ok;
  logic [63:0] em_pass;
  logic [2:0]  em_ldop, em_ofs;
  logic [63:0] em_result, rdata;

  logic        m_allowin32, mw_valid32, mw_ex32, fwd_busy32;
  logic [63:0] mw_pass32;
  logic [31:0] mw_result32, fwd_data32;
  logic        m_allowin64, mw_valid64, mw_ex64, fwd_busy64;
  logic [63:0] mw_pass64;
  logic [63:0] mw_result64, fwd_data64;

  mem_stage_nb #(.DW(32), .PASS_W(64)) u_dut32 (
    .clk       (clk),
    .rstn      (rstn),
    .w_allowin (w_allowin),
    .m_allowin (m_allowin32),
    .em_valid  (em_valid),
    .em_pass   (em_pass),
    .em_load   (em_load),
    .em_ldop   (em_ldop),
    .em_ofs    (em_ofs[1:0]),
    .em_result (em_result[31:0]),
    .em_ex     (em_ex),
    .flush     (flush),
    .data_ok   (data_ok),
    .rdata     (rdata[31:0]),
    .mw_valid  (mw_valid32),
    .mw_pass   (mw_pass32),
    .mw_result (mw_result32),
    .mw_ex     (mw_ex32),
    .fwd_busy  (fwd_busy32),
    .fwd_data  (fwd_data32)
  );

  mem_stage_nb #(.DW(64), .PASS_W(64)) u_dut64 (
    .clk       (clk),
    .rstn      (rstn),
    .w_allowin (w_allowin),
    .m_allowin (m_allowin64),
    .em_valid  (em_valid),
    .em_pass   (em_pass),
    .em_load   (em_load),
    .em_ldop   (em_ldop),
    .em_ofs    (em_ofs),
    .em_result (em_result),
    .em_ex     (em_ex),
    .flush     (flush),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .mw_valid  (mw_valid64),
    .mw_pass   (mw_pass64),
    .mw_result (mw_result64),
    .mw_ex     (mw_ex64),
    .fwd_busy  (fwd_busy64),
    .fwd_data  (fwd_data64)
  );

  typedef struct {
    logic        is_load;
    logic        ex;
    logic [2:0]  ldop;
    logic [2:0]  ofs;
    logic [63:0] data;   // rdata for loads, em_result otherwise
    int          delay;  // cycles in WAIT before data_ok
    int          stall;  // cycles of w_allowin=0 starting with the data_ok cycle
    logic [31:0] exp32;
    logic [63:0] exp64;
  } vec_t;

  typedef struct {
    logic [63:0] result;
    logic        ex;
    logic [63:0] pass;
  } exp_t;

  vec_t vecs [9];
  exp_t q32 [$];
  exp_t q64 [$];
  exp_t e32, e64;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] r32, input logic [63:0] r64, input logic ex,
                          input logic [63:0] pass);
    q32.push_back('{r32, ex, pass});
    q64.push_back('{r64, ex, pass});
  endtask

  // Scoreboard pop on every WB handshake.
  always @(negedge clk) begin
    if (rstn === 1'b1 && mw_valid32 === 1'b1 && w_allowin === 1'b1) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb32_unexpected: got mw_valid with result %h, expected no output",
                 mw_result32);
      end else begin
        e32 = q32.pop_front();
        chk("sb32_result", 64'(mw_result32), e32.result);
        chk("sb32_ex", 64'(mw_ex32), 64'(e32.ex));
        chk("sb32_pass", mw_pass32, e32.pass);
      end
    end
    if (rstn === 1'b1 && mw_valid64 === 1'b1 && w_allowin === 1'b1) begin
      if (q64.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb64_unexpected: got mw_valid with result %h, expected no output",
                 mw_result64);
      end else begin
        e64 = q64.pop_front();
        chk("sb64_result", mw_result64, e64.result);
        chk("sb64_ex", 64'(mw_ex64), 64'(e64.ex));
        chk("sb64_pass", mw_pass64, e64.pass);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    em_valid  = 1'b1;
    em_load   = v.is_load;
    em_ex     = v.ex;
    em_ldop   = v.ldop;
    em_ofs    = v.ofs;
    em_pass   = 64'hCAFE_0000_0000_0000 | 64'(idx);
    em_result = (v.is_load && !v.ex) ? 64'h5555_5555_5555_5555 : v.data;
    rdata     = '0;
    data_ok   = 1'b0;
    w_allowin = 1'b1;
    push_exp(64'(v.exp32), v.exp64, v.ex, em_pass);
    @(negedge clk);
    chk("accept_allowin32", 64'(m_allowin32), 64'd1);
    chk("accept_allowin64", 64'(m_allowin64), 64'd1);
    tick();
    em_valid = 1'b0;
    em_load  = 1'b0;
    em_ex    = 1'b0;
    if (v.is_load && !v.ex) begin
      repeat (v.delay) begin
        @(negedge clk);
        chk("wait_fwd_busy32", 64'(fwd_busy32), 64'd1);
        chk("wait_fwd_busy64", 64'(fwd_busy64), 64'd1);
        chk("wait_mw_valid64", 64'(mw_valid64), 64'd0);
        tick();
      end
      data_ok   = 1'b1;
      rdata     = v.data;
      w_allowin = (v.stall == 0);
      @(negedge clk);
      chk("resp_mw_valid32", 64'(mw_valid32), 64'd1);
      chk("resp_mw_valid64", 64'(mw_valid64), 64'd1);
      chk("resp_fwd_busy64", 64'(fwd_busy64), 64'd0);
      chk("resp_fwd_data32", 64'(fwd_data32), 64'(v.exp32));
      chk("resp_fwd_data64", fwd_data64, v.exp64);
      tick();
      if (v.stall > 0) begin
        for (int s = 1; s < v.stall; s++) begin
          data_ok   = (s == 1);  // stray response while held must be ignored
          rdata     = ~v.data;
          w_allowin = 1'b0;
          @(negedge clk);
          chk("held_result32", 64'(mw_result32), 64'(v.exp32));
          chk("held_result64", mw_result64, v.exp64);
          chk("held_allowin32", 64'(m_allowin32), 64'd0);
          chk("held_allowin64", 64'(m_allowin64), 64'd0);
          tick();
        end
        data_ok   = 1'b0;
        rdata     = ~v.data;
        w_allowin = 1'b1;
        @(negedge clk);
        chk("release_valid64", 64'(mw_valid64), 64'd1);
        tick();
      end
      data_ok = 1'b0;
    end else begin
      @(negedge clk);
      chk("nl_mw_valid32", 64'(mw_valid32), 64'd1);
      chk("nl_fwd_busy32", 64'(fwd_busy32), 64'd0);
      chk("nl_fwd_busy64", 64'(fwd_busy64), 64'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'b000, 3'd0, 64'h0000_0000_0000_1234, 0, 0,
                32'h0000_1234, 64'h0000_0000_0000_1234};
    vecs[1] = '{1'b1, 1'b0, 3'b000, 3'd3, 64'h0000_0000_80FF_0000, 2, 0,
                32'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[2] = '{1'b1, 1'b0, 3'b101, 3'd2, 64'h0000_0000_BEEF_1234, 1, 3,
                32'h0000_BEEF, 64'h0000_0000_0000_BEEF};
    vecs[3] = '{1'b1, 1'b0, 3'b110, 3'd4, 64'h8000_0001_DEAD_BEEF, 1, 0,
                32'hDEAD_BEEF, 64'h0000_0000_8000_0001};
    vecs[4] = '{1'b1, 1'b0, 3'b011, 3'd0, 64'h8000_0001_DEAD_BEEF, 1, 0,
                32'hDEAD_BEEF, 64'h8000_0001_DEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 3'b001, 3'd6, 64'h8123_4567_0000_F00D, 3, 0,
                32'h0000_0000, 64'hFFFF_FFFF_FFFF_8123};
    vecs[6] = '{1'b1, 1'b0, 3'b010, 3'd0, 64'h0000_0000_8765_4321, 1, 1,
                32'h8765_4321, 64'hFFFF_FFFF_8765_4321};
    vecs[7] = '{1'b1, 1'b1, 3'b000, 3'd0, 64'h0000_0000_0000_ABCD, 0, 0,
                32'h0000_ABCD, 64'h0000_0000_0000_ABCD};
    vecs[8] = '{1'b1, 1'b0, 3'b100, 3'd5, 64'h0000_9A00_0000_C300, 1, 0,
                32'h0000_00C3, 64'h0000_0000_0000_009A};

    rstn      = 1'b0;
    w_allowin = 1'b1;
    em_valid  = 1'b0;
    em_load   = 1'b0;
    em_ex     = 1'b0;
    em_ldop   = '0;
    em_ofs    = '0;
    em_pass   = '0;
    em_result = '0;
    flush     = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mw_valid32", 64'(mw_valid32), 64'd0);
    chk("rst_mw_valid64", 64'(mw_valid64), 64'd0);
    chk("rst_allowin32", 64'(m_allowin32), 64'd1);
    chk("rst_allowin64", 64'(m_allowin64), 64'd1);
    chk("rst_fwd_busy64", 64'(fwd_busy64), 64'd0);
    chk("rst_result32", 64'(mw_result32), 64'd0);
    chk("rst_result64", mw_result64, 64'd0);
    chk("rst_mw_ex64", 64'(mw_ex64), 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Flush with a load waiting in M and another load issued from EX: two responses to drain.
    em_valid = 1'b1;
    em_load  = 1'b1;
    em_ldop  = 3'b000;
    em_ofs   = 3'd0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_mw_valid32", 64'(mw_valid32), 64'd0);
    chk("flush_mw_valid64", 64'(mw_valid64), 64'd0);
    tick();
    flush     = 1'b0;
    em_load   = 1'b0;
    em_result = 64'h0000_0000_0000_0077;
    em_pass   = 64'hCAFE_0000_0000_0077;
    rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      data_ok = c[0];
      @(negedge clk);
      chk("drain_allowin32", 64'(m_allowin32), 64'd0);
      chk("drain_allowin64", 64'(m_allowin64), 64'd0);
      chk("drain_mw_valid64", 64'(mw_valid64), 64'd0);
      chk("drain_fwd_busy32", 64'(fwd_busy32), 64'd0);
      tick();
    end
    data_ok = 1'b0;
    push_exp(64'h77, 64'h77, 1'b0, em_pass);
    @(negedge clk);
    chk("drained_allowin32", 64'(m_allowin32), 64'd1);
    chk("drained_allowin64", 64'(m_allowin64), 64'd1);
    tick();
    em_valid = 1'b0;
    @(negedge clk);
    tick();

    // Flush coinciding with the response: consumed, nothing left to drain.
    em_valid = 1'b1;
    em_load  = 1'b1;
    tick();
    em_valid = 1'b0;
    em_load  = 1'b0;
    flush    = 1'b1;
    data_ok  = 1'b1;
    rdata    = 64'h0000_0000_0000_0080;
    @(negedge clk);
    chk("flushok_mw_valid32", 64'(mw_valid32), 64'd0);
    chk("flushok_mw_valid64", 64'(mw_valid64), 64'd0);
    tick();
    flush   = 1'b0;
    data_ok = 1'b0;
    @(negedge clk);
    chk("flushok_allowin32", 64'(m_allowin32), 64'd1);
    chk("flushok_allowin64", 64'(m_allowin64), 64'd1);
    tick();

    // Reset while a load waits for data.
    em_valid = 1'b1;
    em_load  = 1'b1;
    tick();
    em_valid = 1'b0;
    em_load  = 1'b0;
    @(negedge clk);
    chk("prerst_fwd_busy32", 64'(fwd_busy32), 64'd1);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_mw_valid32", 64'(mw_valid32), 64'd0);
    chk("midrst_mw_valid64", 64'(mw_valid64), 64'd0);
    chk("midrst_allowin32", 64'(m_allowin32), 64'd1);
    chk("midrst_allowin64", 64'(m_allowin64), 64'd1);
    chk("midrst_fwd_busy64", 64'(fwd_busy64), 64'd0);
    tick();

    chk("sb32_empty", 64'(q32.size()), 64'd0);
    chk("sb64_empty", 64'(q64.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_nb.md
Name: mem_stage_nb

Overview:
- Parametrised successor to the current memory stage.
- Sits between EX and WB and talks to a split-transaction data bus. EX issues the load request (req/addr_ok); this stage waits for data_ok.
- Extracts and extends the loaded byte, half, word or dword, holds the result under WB back-pressure, and discards responses that belong to flushed loads.
- Generalised in data width (32/64) and carries an opaque pass-through bus instead of fixed fields.

Parameters:
- DW, 32, data path width; legal values 32 or 64.
- PASS_W, 64, width of the opaque pass-through bus (pc, dest, csr fields, etc.).
- OFS_W, log2(DW/8), number of byte-offset bits of vaddr.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- w_allowin  in  1  WB can accept this cycle
- m_allowin  out  1  this stage can accept from EX
- em_valid  in  1  EX presents an instruction
- em_pass  in  PASS_W  opaque payload, forwarded unchanged
- em_load  in  1  instruction is a load whose request was accepted (addr_ok) in EX
- em_ldop  in  3  [1:0] size (0 byte, 1 half, 2 word, 3 dword; dword only if DW=64), [2] zero-extend
- em_ofs  in  OFS_W  vaddr byte offset
- em_result  in  DW  non-load ALU/CSR result
- em_ex  in  1  exception already flagged upstream
- flush  in  1  exception/ertn flush from WB
- data_ok  in  1  load response valid
- rdata  in  DW  load response data
- mw_valid  out  1  valid to WB
- mw_pass  out  PASS_W  payload to WB
- mw_result  out  DW  final result
- mw_ex  out  1  exception flag to WB
- fwd_busy  out  1  M holds a load with no data yet; decode must stall on a hazard
- fwd_data  out  DW  forwarding value; equals mw_result

Behaviour:
- Reset:
  - Synchronous, active-low reset rstn; clock clk.
  - On reset, clear state and m_valid; cancel_cnt=0; all registered fields=0.
  - Outputs after reset: mw_valid=0, m_allowin=1, fwd_busy=0, mw_result=0, mw_ex=0.
- States:
  - IDLE: empty, or holding a non-load.
  - WAIT: load awaiting data_ok.
  - HELD: load data captured, WB stalled.
  - DRAIN: cancel_cnt!=0.
- Flow control:
  - ready_go = !load_M || data_ok || HELD.
  - mw_valid = m_valid && ready_go && !flush.
  - m_allowin = (!m_valid || (ready_go && w_allowin)) && cancel_cnt==0.
- Accept (em_valid && m_allowin && !flush):
  - Latch all em_* fields.
  - Enter WAIT if em_load && !em_ex, else IDLE.
  - When neither accepting nor advancing, registers hold.
- WAIT:
  - data_ok && w_allowin: result passes combinationally (zero added latency); next state depends on the new accept.
  - data_ok && !w_allowin: capture rdata, go to HELD.
  - A data_ok arriving in the same cycle the load enters M is not possible (earliest response is one cycle after accept). The bench does not drive this case.
- HELD: leave when w_allowin; bus data_ok is ignored here.
- Load extraction:
  - lane = em_ofs aligned to the access size; select bytes [lane*8 +: size].
  - Sign- or zero-extend to DW per ldop[2].
  - Misaligned offsets are trapped in EX and never reach this stage.
  - For DW=32, ldop size 3 is treated as word.
- mw_result: extracted load data if load_M, else the latched em_result.
- mw_ex: m_valid && em_ex latched.
- Flush:
  - Clears m_valid next cycle; mw_valid is forced 0 in the flush cycle.
  - cancel_cnt += (state==WAIT && !data_ok) + (em_valid && em_load && !em_ex).
  - cancel_cnt is 2 bits, saturating at 2; the bench must never exceed 2.
- DRAIN:
  - Each data_ok decrements cancel_cnt and is discarded; no register update.
  - m_allowin=0 until the count reaches 0, then enter IDLE.
  - A flush during DRAIN adds to the count per the rule above.
- Forwarding: fwd_busy = m_valid && state==WAIT && !data_ok.
- Simultaneous flush and data_ok in WAIT: the response belongs to the flushed load; it is consumed and not counted.

Test Plan:
- Non-load pass-through: em_result=0x1234 with w_allowin=1 -> mw_valid=1 next cycle, mw_result=0x1234, fwd_busy=0.
- Signed byte load: DW=32, ofs=3, ldop=0, rdata=0x80FF_0000 delayed 2 cycles -> fwd_busy=1 for 2 cycles, then mw_result=0xFFFF_FF80 with data_ok.
- Back-pressure: unsigned half load, ofs=2, rdata=0xBEEF_1234, w_allowin=0 for 3 cycles -> HELD, mw_result=0x0000_BEEF stable, m_allowin=0; a spurious data_ok during HELD is ignored.
- Flush with two pending loads: flush while M is in WAIT and EX presents a load -> cancel_cnt=2; next two data_ok discarded; m_allowin=0 until the 2nd, mw_valid stays 0.
- DW=64 dword load and zero-extended word load: ofs=4, rdata=0x8000_0001_xxxx_xxxx -> mw_result=0x0000_0000_8000_0001.
- Reset asserted mid-WAIT -> next cycle mw_valid=0, cancel_cnt=0, m_allowin=1.
